// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to a 16-bit word memory, hands loads and
// ALU results to write-back through a registered valid/ready slot, counts retirements.
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              mem_signal_write,
  output logic [ADDR_W-1:0] mem_addr_write,
  output logic [DATA_W-1:0] mem_data_write,
  output logic [ADDR_W-1:0] mem_addr_read,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);
  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
  } s_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              reg_write;
  } w_t;

  s_t s_q, s_d;
  w_t w_q, w_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;
  logic s_is_store, s_is_load, s_retire, w_fill, accept;

  always_comb begin
    s_is_store = s_q.valid && (s_q.op == OP_STORE);
    s_is_load  = s_q.valid && (s_q.op == OP_LOAD);
    // op[1] set means store or bubble: these never wait on the write-back slot
    s_retire   = s_q.valid && (s_q.op[1] || !w_q.valid || wb_ready);
    w_fill     = s_retire && !s_q.op[1];
    accept     = ex_valid && (!s_q.valid || s_retire);

    s_d = s_q;
    if (accept) begin
      s_d.valid = 1'b1;
      s_d.op    = ex_op;
      s_d.addr  = ex_addr;
      s_d.data  = ex_data;
      s_d.rd    = ex_rd;
    end else if (s_retire) begin
      s_d.valid = 1'b0;
    end

    // Load data is captured at the edge the entry moves into W
    w_d = w_q;
    if (w_fill) begin
      w_d.valid     = 1'b1;
      w_d.rd        = s_q.rd;
      w_d.data      = (s_q.op == OP_LOAD) ? mem_data_read : s_q.data;
      w_d.reg_write = 1'b1;
    end else if (w_q.valid && wb_ready) begin
      w_d.valid     = 1'b0;
      w_d.reg_write = 1'b0;
    end

    rd_addr_d   = s_is_load ? s_q.addr : rd_addr_q;
    load_cnt_d  = load_cnt_q + ((w_fill && s_q.op == OP_LOAD) ? CNT_W'(1) : CNT_W'(0));
    store_cnt_d = store_cnt_q + (s_is_store ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_q         <= '0;
      w_q         <= '0;
      rd_addr_q   <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      s_q         <= s_d;
      w_q         <= w_d;
      rd_addr_q   <= rd_addr_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign ex_ready         = !s_q.valid || s_retire;
  assign mem_signal_write = s_is_store;
  assign mem_addr_write   = s_q.addr;
  assign mem_data_write   = s_q.data;
  assign mem_addr_read    = rd_addr_d;
  assign wb_valid         = w_q.valid;
  assign wb_rd            = w_q.rd;
  assign wb_data          = w_q.data;
  assign wb_reg_write     = w_q.reg_write;
  assign load_count       = load_cnt_q;
  assign store_count      = store_cnt_q;

  logic unused_pass;
  assign unused_pass = (OP_PASS == 2'b00);
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: word memory model plus an in-order
// write-back scoreboard filled at accept time and drained when W is consumed.
module tb_mem_access_stage;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_op = 2'b11;
  logic [7:0]  ex_addr = '0;
  logic [15:0] ex_data = '0;
  logic [2:0]  ex_rd = '0;
  logic        mem_signal_write;
  logic [7:0]  mem_addr_write, mem_addr_read;
  logic [15:0] mem_data_write, mem_data_read;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_reg_write;
  logic [15:0] load_count, store_count;

  mem_access_stage dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_addr(ex_addr),
    .ex_data(ex_data), .ex_rd(ex_rd),
    .mem_signal_write(mem_signal_write), .mem_addr_write(mem_addr_write),
    .mem_data_write(mem_data_write), .mem_addr_read(mem_addr_read),
    .mem_data_read(mem_data_read),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .load_count(load_count), .store_count(store_count)
  );

  always #5 clock = ~clock;

  // Memory model; poke lets the bench change a word behind the stage's back
  logic [15:0] mem [256] = '{default: 16'h0000};
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  always @(posedge clock) begin
    if (mem_signal_write) mem[mem_addr_write] <= mem_data_write;
    if (poke_en)          mem[poke_addr]      <= poke_data;
  end
  assign mem_data_read = mem[mem_addr_read];

  typedef struct { logic [2:0] rd; logic [15:0] data; } sb_t;
  sb_t         sb[$];
  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  int errors = 0, checks = 0, writes = 0, stalls = 0, w0, s0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the falling edge: counts writes, drains the scoreboard
  task automatic mon();
    sb_t e;
    if (mem_signal_write) writes++;
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_data", wb_data, e.data);
        chk("wb_reg_write", wb_reg_write, 1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clock); mon();
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Presents one op and returns 1 ns after the edge that accepted it
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                      input logic [2:0] rd);
    sb_t e;
    logic ok = 1'b0;
    ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_data = d; ex_rd = rd;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock); mon();
      ok = ex_ready;
      if (!ok) stalls++;
      @(posedge clock); #1;
    end
    ex_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      e.rd = rd;
      case (op)
        2'b00: begin e.data = d; sb.push_back(e); end
        2'b01: begin e.data = ref_mem[a]; sb.push_back(e); end
        2'b10: ref_mem[a] = d;
        default: ;
      endcase
    end
  endtask

  initial begin
    // Reset held with a store presented: nothing may be issued
    ex_valid = 1'b1; ex_op = 2'b10; ex_addr = 8'h11; ex_data = 16'h1111;
    repeat (3) tick();
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_wr", mem_signal_write, 0);
    chk("rst_waddr", mem_addr_write, 0);
    chk("rst_wdata", mem_data_write, 0);
    chk("rst_raddr", mem_addr_read, 0);
    chk("rst_wb", {wb_valid, wb_reg_write, wb_rd, wb_data}, 0);
    chk("rst_cnt", {load_count, store_count}, 0);
    chk("rst_writes", writes, 0);
    ex_valid = 1'b0;
    reset_n = 1'b1;
    idle(1);

    // Store then load of the same word
    w0 = writes;
    send(2'b10, 8'h10, 16'hBEEF, 3'd0);
    chk("st_pulse", mem_signal_write, 1);
    chk("st_addr", mem_addr_write, 8'h10);
    chk("st_data", mem_data_write, 16'hBEEF);
    send(2'b01, 8'h10, 16'h0000, 3'd3);
    chk("st_pulse_end", mem_signal_write, 0);
    chk("ld_raddr", mem_addr_read, 8'h10);
    tick();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_wb_rd", wb_rd, 3);
    tick();
    chk("st_count1", store_count, 1);
    chk("ld_count1", load_count, 1);
    chk("st_once", writes - w0, 1);

    // Back-to-back pass-through at full throughput
    s0 = stalls;
    for (int i = 1; i <= 4; i++) begin
      send(2'b00, 8'h00, 16'(i), 3'(i));
      if (i > 1) begin
        chk("pt_wb_valid", wb_valid, 1);
        chk("pt_wb_data", wb_data, i - 1);
      end
    end
    tick();
    chk("pt_last", {wb_valid, wb_data}, {1'b1, 16'h0004});
    chk("pt_no_stall", stalls - s0, 0);
    idle(2);

    // Back-pressure: load A in W, load B stalled in S, store waiting behind
    wb_ready = 1'b0;
    w0 = writes;
    send(2'b01, 8'h10, 16'h0000, 3'd1);
    send(2'b01, 8'h20, 16'h0000, 3'd2);
    ex_valid = 1'b1; ex_op = 2'b10; ex_addr = 8'h30; ex_data = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      chk("bp_ex_ready", ex_ready, 0);
      chk("bp_no_write", mem_signal_write, 0);
      chk("bp_raddr", mem_addr_read, 8'h20);
      chk("bp_w_hold", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd1, 16'hBEEF});
      if (k == 0) begin poke_en = 1'b1; poke_addr = 8'h20; poke_data = 16'h5A5A; end
      tick();
      poke_en = 1'b0;
    end
    // B's data must be what memory holds when it leaves S
    ref_mem[8'h20] = 16'h5A5A;
    sb[sb.size()-1].data = 16'h5A5A;
    wb_ready = 1'b1;
    send(2'b10, 8'h30, 16'h1234, 3'd0);
    chk("bp_st_in_s", mem_signal_write, 1);
    chk("bp_raddr_held", mem_addr_read, 8'h20);
    chk("bp_b_in_w", {wb_valid, wb_data}, {1'b1, 16'h5A5A});
    idle(2);
    chk("bp_st_once", writes - w0, 1);
    chk("bp_mem", mem[8'h30], 16'h1234);

    // Store and bubble retire while W is full and blocked
    wb_ready = 1'b0;
    w0 = writes; s0 = stalls;
    send(2'b00, 8'h00, 16'h0055, 3'd5);
    send(2'b10, 8'h40, 16'hCAFE, 3'd0);
    send(2'b11, 8'h00, 16'h0000, 3'd0);
    chk("sb_mem", mem[8'h40], 16'hCAFE);
    tick();
    chk("sb_ex_ready", ex_ready, 1);
    chk("sb_w_hold", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd5, 16'h0055});
    chk("sb_no_stall", stalls - s0, 0);
    chk("sb_st_once", writes - w0, 1);
    wb_ready = 1'b1;
    idle(2);

    // Store counter wrap after a fresh reset
    reset_n = 1'b0; sb.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 65537; i++) send(2'b10, 8'(i), 16'(i), 3'd0);
    tick();
    chk("wrap_store", store_count, 1);
    chk("wrap_load", load_count, 0);
    chk("wrap_mem", mem[8'hFF], ref_mem[8'hFF]);

    // Reset while a store sits in S: it must not reach memory
    ex_valid = 1'b1; ex_op = 2'b10; ex_addr = 8'h99; ex_data = 16'hDEAD;
    tick();
    ex_valid = 1'b0;
    chk("mid_st_in_s", mem_signal_write, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_wr_drop", mem_signal_write, 0);
    chk("mid_cnt", {load_count, store_count}, 0);
    chk("mid_ex_ready", ex_ready, 1);
    tick();
    reset_n = 1'b1;
    idle(2);
    chk("mid_mem", mem[8'h99], ref_mem[8'h99]);
    chk("mid_store_cnt", store_count, 0);

    for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
